seq_multiplier_nbit: RTL and testbench

//   Sequential unsigned shift-add multiplier. It produces the 2n-bit product
//   for the calculator's multiply operation; this result drives the

---
 rtl/seq_multiplier_nbit.sv | 106 ++++++++++
 tb/tb_seq_multiplier_nbit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier_nbit.sv
// Sequential unsigned shift-add multiplier: one partial product per clock,
// 2n-bit product held in p until the next completed operation.
module seq_multiplier_nbit #(
  parameter int n = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [n-1:0]   x,
  input  logic [n-1:0]   y,
  output logic [2*n-1:0] p,
  output logic           busy,
  output logic           done
);

  // state | meaning
  // IDLE  | waiting for start; operands not yet captured
  // BUSY  | one shift-add iteration per clock, n iterations total
  // DONE  | p just updated; done pulse; may accept a new start
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = (n > 2) ? $clog2(n) : 1;
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  state_t         state_q, state_d;
  logic [2*n-1:0] acc_q, acc_d;
  logic [2*n-1:0] mcand_q, mcand_d;
  logic [n-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  count_q, count_d;
  logic [2*n-1:0] p_q, p_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [2*n-1:0] acc_sum;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    p_d      = p_q;
    acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = {{n{1'b0}}, x};
          mplier_d = y;
          count_d  = '0;
          state_d  = BUSY;
        end else begin
          state_d  = IDLE;
        end
      end
      BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (count_q == LAST) begin
          // count is parked at zero rather than wrapping past n-1
          count_d = '0;
          p_d     = acc_sum;
          state_d = DONE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == BUSY);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      p_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      p_q      <= p_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign p    = p_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_seq_multiplier_nbit.sv
// Directed bench for seq_multiplier_nbit (n=4): handshake timing, corner
// products, ignored start while busy, back-to-back ops and mid-op reset.
module tb_seq_multiplier_nbit;

  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [N-1:0]   x;
  logic [N-1:0]   y;
  logic [2*N-1:0] p;
  logic           busy;
  logic           done;

  int n_checks;
  int n_pass;

  seq_multiplier_nbit #(.n(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y),
    .p     (p),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    else
      n_pass++;
  endtask

  // Pulse start for one edge, then wait for done. cyc counts edges from the
  // accepting edge through the edge that raises done (n+1 expected).
  task automatic do_mul(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [2*N-1:0] exp, input string tag);
    int cyc;
    int busy_cnt;
    logic p_moved;
    logic [2*N-1:0] p_prev;
    x = a;
    y = b;
    start = 1'b1;
    p_prev = p;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    busy_cnt = 0;
    p_moved = 1'b0;
    while (!done && cyc < 20) begin
      if (busy) busy_cnt++;
      if (p !== p_prev) p_moved = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, cyc, N + 1);
    check({tag, " busy cycles"}, busy_cnt, N);
    check({tag, " p stable while busy"}, {31'd0, p_moved}, 0);
    check({tag, " p at done"}, p, exp);
    check({tag, " busy low at done"}, {31'd0, busy}, 0);
    @(negedge clk);
    check({tag, " done single pulse"}, {31'd0, done}, 0);
    check({tag, " p held"}, p, exp);
  endtask

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] prod;
  } vec_t;

  vec_t corners[4] = '{
    '{4'd0,  4'd9,  8'd0},
    '{4'd9,  4'd0,  8'd0},
    '{4'd1,  4'd15, 8'd15},
    '{4'd15, 4'd15, 8'd225}
  };

  initial begin
    int cyc;
    int busy_cnt;
    int extra_done;
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    start = 1'b1;
    x = 4'd3;
    y = 4'd5;

    // reset held with start asserted
    repeat (3) @(negedge clk);
    check("reset p", p, 0);
    check("reset busy", {31'd0, busy}, 0);
    check("reset done", {31'd0, done}, 0);

    // release; start is accepted on the very first edge
    rst_n = 1'b1;
    do_mul(4'd3, 4'd5, 8'd15, "3x5");

    foreach (corners[i])
      do_mul(corners[i].a, corners[i].b, corners[i].prod, $sformatf("corner%0d", i));

    // start pulsed mid-op with new operands is ignored
    x = 4'd7; y = 4'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    x = 4'd2; y = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 3;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("ignore latency", cyc, N + 1);
    check("ignore p", p, 42);
    extra_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    check("ignore no extra done", extra_done, 0);
    check("ignore p held", p, 42);

    // start held high: back-to-back ops
    x = 4'd2; y = 4'd3; start = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b first latency", cyc, N + 1);
    check("b2b first p", p, 6);
    check("b2b busy low in done", {31'd0, busy}, 0);
    x = 4'd4; y = 4'd4;
    @(negedge clk);
    check("b2b p kept on restart", p, 6);
    cyc = 1;
    busy_cnt = 0;
    while (!done && cyc < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    check("b2b period", cyc, N + 1);
    check("b2b busy cycles", busy_cnt, N);
    check("b2b second p", p, 16);
    start = 1'b0;
    @(negedge clk);
    check("b2b back to idle", {31'd0, busy}, 0);

    // reset mid-op aborts and clears p
    do_mul(4'd12, 4'd11, 8'd132, "12x11");
    x = 4'd5; y = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort busy before reset", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    check("abort p async", p, 0);
    check("abort busy async", {31'd0, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_mul(4'd5, 4'd5, 8'd25, "5x5 after reset");
    extra_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    check("after reset no extra done", extra_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
